// File: rtl/break_variable_selector_pkg.sv
// Shared types, widths and literal helpers for the break-variable selector.
// Literal layout: MSB = negation flag, low VAR_W bits = variable index (0 = empty slot).
package break_variable_selector_pkg;

  localparam int unsigned NSAT     = 3;
  localparam int unsigned LIT_W    = 12;
  localparam int unsigned VAR_W    = LIT_W - 1;
  localparam int unsigned BREAK_W  = 8;
  localparam int unsigned NOISE_W  = 8;
  localparam int unsigned RAND_W   = 32;
  localparam int unsigned CLAUSE_W = NSAT * LIT_W;
  localparam int unsigned SLOT_W   = 2;   // holds 0..NSAT-1
  localparam int unsigned CNT_W    = 2;   // holds 0..NSAT
  localparam int unsigned RANK_LSB = 16;  // random_i[23:16] scales the noise rank
  localparam int unsigned RANK_W   = 8;
  localparam int unsigned PROD_W   = RANK_W + CNT_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bvs_state_e;

  // Running-minimum record: candidate or current best slot.
  typedef struct packed {
    logic               valid;
    logic [BREAK_W-1:0] brk;
    logic [SLOT_W-1:0]  slot;
  } best_t;

  // Variable index of a clause slot; the sign bit is dropped.
  function automatic logic [VAR_W-1:0] slot_var(input logic [CLAUSE_W-1:0] clause,
                                                input logic [SLOT_W-1:0]   slot);
    return clause[32'(slot) * LIT_W +: VAR_W];
  endfunction

  // One bit per slot holding a non-zero variable.
  function automatic logic [NSAT-1:0] valid_mask(input logic [CLAUSE_W-1:0] clause);
    logic [NSAT-1:0] mask;
    mask = '0;
    for (int k = 0; k < int'(NSAT); k++) begin
      mask[k] = (slot_var(clause, SLOT_W'(k)) != '0);
    end
    return mask;
  endfunction

  function automatic logic [CNT_W-1:0] count_valid(input logic [NSAT-1:0] mask);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int k = 0; k < int'(NSAT); k++) begin
      cnt = cnt + CNT_W'(mask[k]);
    end
    return cnt;
  endfunction

  // Slot index of the rank-th set bit (0-based, ascending slot order).
  function automatic logic [SLOT_W-1:0] nth_valid_slot(input logic [NSAT-1:0]   mask,
                                                       input logic [SLOT_W-1:0] rank);
    logic [SLOT_W-1:0] result;
    logic [CNT_W-1:0]  seen;
    logic              found;
    result = '0;
    seen   = '0;
    found  = 1'b0;
    for (int k = 0; k < int'(NSAT); k++) begin
      if (mask[k]) begin
        if (!found && (seen == CNT_W'(rank))) begin
          result = SLOT_W'(k);
          found  = 1'b1;
        end
        seen = seen + CNT_W'(1);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/break_variable_selector_if.sv
// Bus bundle for the break-variable selector: clause input, break-memory
// read port and the flip result handshake.
//   slave  : the selector (consumes clause/read data/ready, drives strobes/result)
//   master : the surrounding pipeline and break memory
interface break_variable_selector_if;
  import break_variable_selector_pkg::*;

  logic                clause_valid_i;
  logic [CLAUSE_W-1:0] clause_i;
  logic [RAND_W-1:0]   random_i;
  logic [NOISE_W-1:0]  noise_threshold_i;

  logic                brk_rd_en_o;
  logic [VAR_W-1:0]    brk_rd_addr_o;
  logic [BREAK_W-1:0]  brk_rd_data_i;

  logic                flip_valid_o;
  logic                flip_ready_i;
  logic [VAR_W-1:0]    flip_var_o;
  logic [BREAK_W-1:0]  flip_break_o;
  logic                flip_noise_o;

  modport slave (
    input  clause_valid_i, clause_i, random_i, noise_threshold_i,
    input  brk_rd_data_i, flip_ready_i,
    output brk_rd_en_o, brk_rd_addr_o,
    output flip_valid_o, flip_var_o, flip_break_o, flip_noise_o
  );

  modport master (
    output clause_valid_i, clause_i, random_i, noise_threshold_i,
    output brk_rd_data_i, flip_ready_i,
    input  brk_rd_en_o, brk_rd_addr_o,
    input  flip_valid_o, flip_var_o, flip_break_o, flip_noise_o
  );

endinterface

// File: rtl/break_variable_selector_min_compare.sv
// Min-compare stage (bvs_min_compare): folds one candidate into the running
// best. Strict less-than, so with slots presented in ascending order a tie
// keeps the lower slot.
//   cand        : {valid, break, slot} of the break word on the read bus
//   best        : current best record
//   next_best_c : updated best record (combinational)
module break_variable_selector_min_compare
  import break_variable_selector_pkg::*;
(
  input  best_t cand,
  input  best_t best,
  output best_t next_best_c
);

  always_comb begin
    next_best_c = best;
    if (cand.valid && (!best.valid || (cand.brk < best.brk))) begin
      next_best_c = cand;
    end
  end

endmodule

// File: rtl/break_variable_selector.sv
// WalkSAT variable choice for one unsatisfied clause. Reads the break count of
// every valid literal (one slot per cycle), then offers either the minimum
// break variable (greedy) or the rank-th valid literal (noise) to the flip
// stage over a valid/ready handshake.
//   clk, reset           : clock, synchronous active-high reset
//   bus (slave)          : clause in, break-memory read port, flip result out
//   clear_debug_i        : clears the sticky debug flags
//   busy_o               : accept .. flip handshake
//   debug_dropped_o      : sticky, clause offered while busy
//   debug_empty_clause_o : sticky, accepted clause had no valid slot
module break_variable_selector
  import break_variable_selector_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  break_variable_selector_if.slave bus,
  input  logic                     clear_debug_i,
  output logic                     busy_o,
  output logic                     debug_dropped_o,
  output logic                     debug_empty_clause_o
);

  bvs_state_e          state;
  logic [SLOT_W-1:0]   slot_q;        // slot whose read strobe is on the bus
  logic [CLAUSE_W-1:0] clause_q;
  logic [NSAT-1:0]     mask_q;
  logic [CNT_W-1:0]    n_valid_q;
  logic                noise_q;
  logic [SLOT_W-1:0]   noise_slot_q;
  logic [BREAK_W-1:0]  noise_brk_q;
  logic                data_vld_q;    // read data on the bus this cycle
  logic [SLOT_W-1:0]   data_slot_q;
  best_t               best_q;

  logic [NSAT-1:0]     in_mask_c;
  logic [CNT_W-1:0]    in_n_valid_c;
  logic                in_noise_c;
  logic [PROD_W-1:0]   rank_prod_c;
  logic [SLOT_W-1:0]   in_rank_c;
  logic [SLOT_W-1:0]   next_slot_c;
  best_t               cand_c;
  best_t               next_best_c;
  logic [BREAK_W-1:0]  noise_brk_c;
  logic [VAR_W-1:0]    res_var_c;
  logic [BREAK_W-1:0]  res_brk_c;
  logic                res_noise_c;
  logic                unused_rand_c;

  // Accept-cycle decode of the incoming clause and random word.
  always_comb begin
    in_mask_c    = valid_mask(bus.clause_i);
    in_n_valid_c = count_valid(in_mask_c);
    in_noise_c   = (bus.random_i[NOISE_W-1:0] < bus.noise_threshold_i);
    rank_prod_c  = PROD_W'(bus.random_i[RANK_LSB +: RANK_W]) * PROD_W'(in_n_valid_c);
    in_rank_c    = rank_prod_c[RANK_W +: SLOT_W];
  end

  assign unused_rand_c = ^{bus.random_i[RAND_W-1:RANK_LSB+RANK_W],
                           bus.random_i[RANK_LSB-1:NOISE_W]};

  assign next_slot_c = slot_q + SLOT_W'(1);

  // Read data returning this cycle, as a min-compare candidate.
  always_comb begin
    cand_c.valid = data_vld_q;
    cand_c.brk   = bus.brk_rd_data_i;
    cand_c.slot  = data_slot_q;
  end

  break_variable_selector_min_compare u_min_compare (
    .cand        (cand_c),
    .best        (best_q),
    .next_best_c (next_best_c)
  );

  // The noise slot's break may still be on the read bus during DRAIN.
  always_comb begin
    noise_brk_c = noise_brk_q;
    if (data_vld_q && (data_slot_q == noise_slot_q)) begin
      noise_brk_c = bus.brk_rd_data_i;
    end
  end

  // Final choice; an empty clause yields var 0 / break 0.
  always_comb begin
    res_var_c   = '0;
    res_brk_c   = '0;
    res_noise_c = 1'b0;
    if (n_valid_q != '0) begin
      if (noise_q) begin
        res_var_c   = slot_var(clause_q, noise_slot_q);
        res_brk_c   = noise_brk_c;
        res_noise_c = 1'b1;
      end else if (next_best_c.valid) begin
        res_var_c   = slot_var(clause_q, next_best_c.slot);
        res_brk_c   = next_best_c.brk;
      end
    end
  end

  // FSM, read sequencing, result registers and debug flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= ST_IDLE;
      slot_q               <= '0;
      clause_q             <= '0;
      mask_q               <= '0;
      n_valid_q            <= '0;
      noise_q              <= 1'b0;
      noise_slot_q         <= '0;
      noise_brk_q          <= '0;
      data_vld_q           <= 1'b0;
      data_slot_q          <= '0;
      best_q               <= '0;
      busy_o               <= 1'b0;
      debug_dropped_o      <= 1'b0;
      debug_empty_clause_o <= 1'b0;
      bus.brk_rd_en_o      <= 1'b0;
      bus.brk_rd_addr_o    <= '0;
      bus.flip_valid_o     <= 1'b0;
      bus.flip_var_o       <= '0;
      bus.flip_break_o     <= '0;
      bus.flip_noise_o     <= 1'b0;
    end else begin
      // Break memory answers one cycle after the strobe.
      data_vld_q  <= bus.brk_rd_en_o;
      data_slot_q <= slot_q;

      // Sticky flags: a set event beats a simultaneous clear.
      if (bus.clause_valid_i && busy_o) begin
        debug_dropped_o <= 1'b1;
      end else if (clear_debug_i) begin
        debug_dropped_o <= 1'b0;
      end

      if ((state == ST_IDLE) && bus.clause_valid_i && (in_n_valid_c == '0)) begin
        debug_empty_clause_o <= 1'b1;
      end else if (clear_debug_i) begin
        debug_empty_clause_o <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          bus.brk_rd_en_o   <= 1'b0;
          bus.brk_rd_addr_o <= '0;
          if (bus.clause_valid_i) begin
            state             <= ST_READ;
            slot_q            <= '0;
            clause_q          <= bus.clause_i;
            mask_q            <= in_mask_c;
            n_valid_q         <= in_n_valid_c;
            noise_q           <= in_noise_c;
            noise_slot_q      <= nth_valid_slot(in_mask_c, in_rank_c);
            noise_brk_q       <= '0;
            best_q            <= '0;
            busy_o            <= 1'b1;
            bus.brk_rd_en_o   <= in_mask_c[0];
            bus.brk_rd_addr_o <= slot_var(bus.clause_i, SLOT_W'(0));
          end
        end

        ST_READ: begin
          best_q      <= next_best_c;
          noise_brk_q <= noise_brk_c;
          if (slot_q == SLOT_W'(NSAT - 1)) begin
            state             <= ST_DRAIN;
            bus.brk_rd_en_o   <= 1'b0;
            bus.brk_rd_addr_o <= '0;
          end else begin
            // Empty slots still take their cycle, just without a strobe.
            slot_q            <= next_slot_c;
            bus.brk_rd_en_o   <= mask_q[next_slot_c];
            bus.brk_rd_addr_o <= slot_var(clause_q, next_slot_c);
          end
        end

        ST_DRAIN: begin
          state            <= ST_DONE;
          best_q           <= next_best_c;
          bus.flip_valid_o <= 1'b1;
          bus.flip_var_o   <= res_var_c;
          bus.flip_break_o <= res_brk_c;
          bus.flip_noise_o <= res_noise_c;
        end

        ST_DONE: begin
          if (bus.flip_ready_i) begin
            state            <= ST_IDLE;
            busy_o           <= 1'b0;
            bus.flip_valid_o <= 1'b0;
            bus.flip_var_o   <= '0;
            bus.flip_break_o <= '0;
            bus.flip_noise_o <= 1'b0;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_break_variable_selector.sv
// Bench for break_variable_selector: directed scenarios followed by random
// clauses, each result compared with a queue-based WalkSAT choice model.
module tb_break_variable_selector;
  import break_variable_selector_pkg::*;

  typedef struct packed {
    logic [VAR_W-1:0]   v;
    logic [BREAK_W-1:0] b;
    logic               n;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic clear_debug_i;
  logic busy_o;
  logic debug_dropped_o;
  logic debug_empty_clause_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [BREAK_W-1:0] brk_mem [0:(1<<VAR_W)-1];
  logic [VAR_W-1:0]   cur_var  [NSAT];
  logic               cur_sign [NSAT];
  logic [VAR_W-1:0]   rd_addr_q [$];
  int                 rd_cyc_q  [$];

  logic [VAR_W-1:0]   obs_var;
  logic [BREAK_W-1:0] obs_brk;
  logic               obs_noise;

  always #5 clk = ~clk;

  break_variable_selector_if bus();

  break_variable_selector dut (
    .clk                  (clk),
    .reset                (reset),
    .bus                  (bus),
    .clear_debug_i        (clear_debug_i),
    .busy_o               (busy_o),
    .debug_dropped_o      (debug_dropped_o),
    .debug_empty_clause_o (debug_empty_clause_o)
  );

  // Break memory (1-cycle read latency) and read-strobe monitor.
  always @(posedge clk) begin
    bus.brk_rd_data_i <= bus.brk_rd_en_o ? brk_mem[bus.brk_rd_addr_o] : BREAK_W'($urandom);
    if (bus.brk_rd_en_o) begin
      rd_addr_q.push_back(bus.brk_rd_addr_o);
      rd_cyc_q.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_clause(input int v0, input int v1, input int v2);
    cur_var[0] = VAR_W'(v0);
    cur_var[1] = VAR_W'(v1);
    cur_var[2] = VAR_W'(v2);
    for (int k = 0; k < int'(NSAT); k++) cur_sign[k] = 1'($urandom);
  endtask

  function automatic logic [CLAUSE_W-1:0] build_clause();
    logic [CLAUSE_W-1:0] c;
    c = '0;
    for (int k = 0; k < int'(NSAT); k++) c[k*LIT_W +: LIT_W] = {cur_sign[k], cur_var[k]};
    return c;
  endfunction

  // WalkSAT choice from the clause and memory contents.
  function automatic exp_t model(input logic [31:0] rnd, input logic [7:0] thr);
    int   vl[$];
    int   s;
    int   rank;
    exp_t e;
    e = '0;
    for (int k = 0; k < int'(NSAT); k++) if (cur_var[k] != 0) vl.push_back(k);
    if (vl.size() == 0) return e;
    if (int'(rnd[7:0]) < int'(thr)) begin
      rank = int'(rnd[23:16]) * vl.size() / 256;
      s = vl[rank];
      e.n = 1'b1;
    end else begin
      s = vl[0];
      foreach (vl[i]) if (brk_mem[cur_var[vl[i]]] < brk_mem[cur_var[s]]) s = vl[i];
    end
    e.v = cur_var[s];
    e.b = brk_mem[cur_var[s]];
    return e;
  endfunction

  // One clause from accept to handshake; result left in obs_*.
  task automatic run_clause(input logic [31:0] rnd, input logic [7:0] thr,
                            input int hold, input bit inject_drop);
    exp_t e;
    int   lat;
    int   t0;
    int   exp_addr[$];
    int   exp_cyc[$];
    e = model(rnd, thr);
    rd_addr_q.delete();
    rd_cyc_q.delete();
    @(negedge clk);
    t0 = cyc;
    for (int k = 0; k < int'(NSAT); k++) begin
      if (cur_var[k] != 0) begin
        exp_addr.push_back(int'(cur_var[k]));
        exp_cyc.push_back(t0 + 1 + k);
      end
    end
    bus.clause_valid_i    = 1'b1;
    bus.clause_i          = build_clause();
    bus.random_i          = rnd;
    bus.noise_threshold_i = thr;
    @(negedge clk);
    bus.clause_valid_i    = 1'b0;
    bus.clause_i          = CLAUSE_W'({$urandom, $urandom});
    bus.random_i          = $urandom;
    bus.noise_threshold_i = 8'($urandom);
    check("busy_after_accept", 32'(busy_o), 32'd1);
    lat = 1;
    while (!bus.flip_valid_o && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd5);
    obs_var   = bus.flip_var_o;
    obs_brk   = bus.flip_break_o;
    obs_noise = bus.flip_noise_o;
    check("flip_var", 32'(obs_var), 32'(e.v));
    check("flip_break", 32'(obs_brk), 32'(e.b));
    check("flip_noise", 32'(obs_noise), 32'(e.n));
    check("read_count", 32'(rd_addr_q.size()), 32'(exp_addr.size()));
    if (rd_addr_q.size() == exp_addr.size()) begin
      foreach (exp_addr[i]) begin
        check("read_addr", 32'(rd_addr_q[i]), 32'(exp_addr[i]));
        check("read_cycle", 32'(rd_cyc_q[i] - t0), 32'(exp_cyc[i] - t0));
      end
    end
    for (int i = 0; i < hold; i++) begin
      if (inject_drop && i == 0) begin
        bus.clause_valid_i = 1'b1;
        bus.clause_i       = CLAUSE_W'({$urandom, $urandom}) | CLAUSE_W'(1);
      end
      @(negedge clk);
      bus.clause_valid_i = 1'b0;
      check("hold_valid", 32'(bus.flip_valid_o), 32'd1);
      check("hold_var", 32'(bus.flip_var_o), 32'(obs_var));
      check("hold_break", 32'(bus.flip_break_o), 32'(obs_brk));
      check("hold_busy", 32'(busy_o), 32'd1);
    end
    bus.flip_ready_i = 1'b1;
    @(negedge clk);
    bus.flip_ready_i = 1'b0;
    check("post_hs_valid", 32'(bus.flip_valid_o), 32'd0);
    check("post_hs_busy", 32'(busy_o), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] thr;
    reset                 = 1'b1;
    clear_debug_i         = 1'b0;
    bus.clause_valid_i    = 1'b0;
    bus.clause_i          = '0;
    bus.random_i          = '0;
    bus.noise_threshold_i = '0;
    bus.flip_ready_i      = 1'b0;
    for (int i = 0; i < (1 << VAR_W); i++) brk_mem[i] = BREAK_W'($urandom);
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_valid", 32'(bus.flip_valid_o), 32'd0);
    check("rst_rd_en", 32'(bus.brk_rd_en_o), 32'd0);
    check("rst_var", 32'(bus.flip_var_o), 32'd0);
    check("rst_dropped", 32'(debug_dropped_o), 32'd0);
    check("rst_empty", 32'(debug_empty_clause_o), 32'd0);
    reset = 1'b0;

    // Greedy minimum.
    set_clause(5, 9, 12);
    brk_mem[5] = 8'd3; brk_mem[9] = 8'd1; brk_mem[12] = 8'd4;
    run_clause(32'h0000_0000, 8'd0, 0, 1'b0);
    check("greedy_var", 32'(obs_var), 32'd9);
    check("greedy_break", 32'(obs_brk), 32'd1);
    check("greedy_noise", 32'(obs_noise), 32'd0);
    check("greedy_no_empty_flag", 32'(debug_empty_clause_o), 32'd0);

    // Tie at zero goes to the lower slot.
    brk_mem[5] = 8'd2; brk_mem[9] = 8'd0; brk_mem[12] = 8'd0;
    run_clause(32'h1234_5678, 8'd0, 1, 1'b0);
    check("tie_var", 32'(obs_var), 32'd9);
    check("tie_break", 32'(obs_brk), 32'd0);

    // Empty slot 2 is never read and never wins, even with break[0] = 0.
    set_clause(7, 8, 0);
    brk_mem[7] = 8'd5; brk_mem[8] = 8'd6; brk_mem[0] = 8'd0;
    run_clause(32'hFFFF_FFFF, 8'd0, 0, 1'b0);
    check("empty_slot_var", 32'(obs_var), 32'd7);
    check("empty_slot_break", 32'(obs_brk), 32'd5);

    // Noise path: rank = (0xC0*3)>>8 = 2.
    set_clause(5, 9, 12);
    brk_mem[5] = 8'd3; brk_mem[9] = 8'd1; brk_mem[12] = 8'd4;
    run_clause(32'h00C0_0010, 8'd255, 0, 1'b0);
    check("noise_var", 32'(obs_var), 32'd12);
    check("noise_break", 32'(obs_brk), 32'd4);
    check("noise_flag", 32'(obs_noise), 32'd1);

    // Backpressure with a clause offered while busy.
    run_clause(32'h0000_0000, 8'd0, 4, 1'b1);
    check("dropped_flag", 32'(debug_dropped_o), 32'd1);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.flip_valid_o) n++;
    end
    check("no_second_result", 32'(n), 32'd0);

    // Empty clause, then clear the sticky flags.
    set_clause(0, 0, 0);
    run_clause(32'h0000_0000, 8'd0, 0, 1'b0);
    check("empty_var", 32'(obs_var), 32'd0);
    check("empty_break", 32'(obs_brk), 32'd0);
    check("empty_flag", 32'(debug_empty_clause_o), 32'd1);
    @(negedge clk);
    clear_debug_i = 1'b1;
    @(negedge clk);
    clear_debug_i = 1'b0;
    check("empty_flag_cleared", 32'(debug_empty_clause_o), 32'd0);
    check("dropped_flag_cleared", 32'(debug_dropped_o), 32'd0);

    // Reset at T+2 aborts the clause.
    set_clause(5, 9, 12);
    @(negedge clk);
    bus.clause_valid_i    = 1'b1;
    bus.clause_i          = build_clause();
    bus.noise_threshold_i = 8'd0;
    @(negedge clk);
    bus.clause_valid_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_valid", 32'(bus.flip_valid_o), 32'd0);
    check("abort_rd_en", 32'(bus.brk_rd_en_o), 32'd0);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.flip_valid_o) n++;
    end
    check("abort_no_result", 32'(n), 32'd0);
    run_clause(32'h0000_0000, 8'd0, 0, 1'b0);
    check("after_abort_var", 32'(obs_var), 32'd9);

    // Random clauses, empty slots and thresholds.
    for (int t = 0; t < 40; t++) begin
      for (int k = 0; k < int'(NSAT); k++) begin
        cur_var[k]  = ($urandom_range(0, 3) == 0) ? VAR_W'(0) : VAR_W'($urandom_range(1, 2047));
        cur_sign[k] = 1'($urandom);
        brk_mem[cur_var[k]] = BREAK_W'($urandom_range(0, 7));
      end
      case ($urandom_range(0, 2))
        0:       thr = 8'd0;
        1:       thr = 8'd255;
        default: thr = 8'($urandom);
      endcase
      run_clause($urandom, thr, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
